// File: rtl/ddr3_dfi_pkg.sv
// ddr3_dfi_pkg: shared definitions for the DDR3 DFI sequencer.
//   ddr3_cmd_e   - DDR3 command encodings as {ras_n, cas_n, we_n}
//   BURST_CYCLES - clock cycles per BL8 burst (two beats per cycle)
//   ODT_CYCLES   - length of the write ODT window
//   DELAY_DEPTH  - depth of the pulse delay lines
//   BLK_CNT_W    - width of the data-bus blocking counters
//   sat_dec()    - decrement that saturates at zero
package ddr3_dfi_pkg;

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_ZQC = 3'b110,
        CMD_NOP = 3'b111
    } ddr3_cmd_e;

    localparam int BURST_CYCLES = 4;
    localparam int ODT_CYCLES   = 2 * BURST_CYCLES;
    localparam int DELAY_DEPTH  = 16;
    localparam int BLK_CNT_W    = 8;

    function automatic logic [BLK_CNT_W-1:0] sat_dec(input logic [BLK_CNT_W-1:0] v);
        return (v == '0) ? v : v - BLK_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ddr3_dfi_seq_if.sv
// ddr3_dfi_seq_if: upstream side of the DFI sequencer.
//   command channel : cmd_vld_i/cmd_rdy_o handshake, cmd_cmd_i {ras_n,cas_n,we_n},
//                     cmd_ba_i bank, cmd_adr_i address
//   write channel   : wr_vld_i/wr_rdy_o, wr_mask_i (1 = write byte), wr_data_i
//                     (two beats, low beat first)
//   read channel    : rd_vld_o, rd_last_o, rd_data_o
// master = memory controller, slave = ddr3_dfi_seq. Parameters must match the
// ones given to ddr3_dfi_seq.
interface ddr3_dfi_seq_if #(
    parameter int DDR3_WIDTH = 16,
    parameter int ADDR_BITS  = 14
);
    localparam int DDR3_MASKS = DDR3_WIDTH / 8;

    logic                      cmd_vld_i;
    logic                      cmd_rdy_o;
    logic [2:0]                cmd_cmd_i;
    logic [2:0]                cmd_ba_i;
    logic [ADDR_BITS-1:0]      cmd_adr_i;

    logic                      wr_vld_i;
    logic                      wr_rdy_o;
    logic [2*DDR3_MASKS-1:0]   wr_mask_i;
    logic [2*DDR3_WIDTH-1:0]   wr_data_i;

    logic                      rd_vld_o;
    logic                      rd_last_o;
    logic [2*DDR3_WIDTH-1:0]   rd_data_o;

    modport master (
        output cmd_vld_i, cmd_cmd_i, cmd_ba_i, cmd_adr_i,
        output wr_vld_i, wr_mask_i, wr_data_i,
        input  cmd_rdy_o, wr_rdy_o, rd_vld_o, rd_last_o, rd_data_o
    );

    modport slave (
        input  cmd_vld_i, cmd_cmd_i, cmd_ba_i, cmd_adr_i,
        input  wr_vld_i, wr_mask_i, wr_data_i,
        output cmd_rdy_o, wr_rdy_o, rd_vld_o, rd_last_o, rd_data_o
    );

endinterface

// File: rtl/ddr3_dfi_delay.sv
// ddr3_dfi_delay: pulse delay line with stretch.
//   clock, reset : system clock, synchronous active-high reset
//   pulse_i      : one-cycle pulse, registered into the line
//   pulse_o      : high from TAP cycles after the line captures pulse_i,
//                  for LEN cycles; overlapping pulses merge
// TAP must be 0..DELAY_DEPTH-1, LEN at least 1.
module ddr3_dfi_delay
    import ddr3_dfi_pkg::*;
#(
    parameter int TAP = 0,
    parameter int LEN = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic pulse_i,
    output logic pulse_o
);
    localparam int CNT_W = $clog2(LEN + 1);

    logic [DELAY_DEPTH-1:0] line_q, line_d;
    logic [CNT_W-1:0]       hold_q, hold_d;

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        line_d = {line_q[DELAY_DEPTH-2:0], pulse_i};
        hold_d = '0;
        // The tap starts the pulse; hold keeps it up for the remaining LEN-1 cycles.
        if (line_q[TAP]) begin
            hold_d = CNT_W'(LEN - 1);
        end else if (hold_q != '0) begin
            hold_d = hold_q - CNT_W'(1);
        end
    end

    // NOTE: the delay line is reset like any other flop so a reset mid-burst kills pending pulses.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            line_q <= '0;
            hold_q <= '0;
        end else begin
            line_q <= line_d;
            hold_q <= hold_d;
        end
    end

    assign pulse_o = line_q[TAP] | (hold_q != '0);

endmodule

// File: rtl/ddr3_dfi_seq.sv
// ddr3_dfi_seq: DFI initiator for the GW2A DDR3 PHY.
//   clock, reset      : DDR3 CK-rate clock, synchronous active-high reset
//   ctl_cke_i/rst_ni  : CKE / RESET# requests, registered onto the DFI
//   up                : upstream command, write-data and read-data channels
//   dfi_*_o           : registered command bus, write strobe/enable, mask and
//                       data (combinational from the write channel), read enable
//   dfi_rvld_i/last_i/data_i : read return, passed straight upstream
//   err_o             : sticky write underrun or unexpected read data
// Only data-bus spacing is enforced here: tCCD, write->read, read->write.
// Optional: define DDR3_DFI_ODT_EN to drive dfi_odt_o around each write.
module ddr3_dfi_seq
    import ddr3_dfi_pkg::*;
#(
    parameter int  DDR3_WIDTH = 16,
    parameter int  ADDR_BITS  = 14,
    parameter int  WR_LATENCY = 5,
    parameter int  RD_LATENCY = 6,
    parameter int  WTR_CYCLES = 13,
    parameter int  RTW_CYCLES = 7,
    localparam int DDR3_MASKS = DDR3_WIDTH / 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ctl_cke_i,
    input  logic                    ctl_rst_ni,
    ddr3_dfi_seq_if.slave           up,
    output logic                    err_o,
    output logic                    dfi_cke_o,
    output logic                    dfi_rst_no,
    output logic                    dfi_cs_no,
    output logic                    dfi_ras_no,
    output logic                    dfi_cas_no,
    output logic                    dfi_we_no,
    output logic                    dfi_odt_o,
    output logic [2:0]              dfi_bank_o,
    output logic [ADDR_BITS-1:0]    dfi_addr_o,
    output logic                    dfi_wstb_o,
    output logic                    dfi_wren_o,
    output logic [2*DDR3_MASKS-1:0] dfi_mask_o,
    output logic [2*DDR3_WIDTH-1:0] dfi_data_o,
    output logic                    dfi_rden_o,
    input  logic                    dfi_rvld_i,
    input  logic                    dfi_last_i,
    input  logic [2*DDR3_WIDTH-1:0] dfi_data_i
);
    ddr3_cmd_e cmd_in;
    logic      is_rd, is_wr, cmd_rdy, accept, rd_issue, wr_issue, underrun, stray_rd;

    logic                 cke_q, cke_d, rst_n_q, rst_n_d, cs_n_q, cs_n_d, err_q, err_d;
    logic [2:0]           cmd_q, cmd_d, bank_q, bank_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [BLK_CNT_W-1:0] ccd_q, ccd_d, wtr_q, wtr_d, rtw_q, rtw_d;
    logic [3:0]           rd_out_q, rd_out_d;

    assign cmd_in = ddr3_cmd_e'(up.cmd_cmd_i);
    assign is_rd  = (cmd_in == CMD_RD);
    assign is_wr  = (cmd_in == CMD_WR);

    // A counter value of 1 expires during this cycle, so it no longer blocks.
    assign cmd_rdy = !reset &&
        !(is_rd && ((ccd_q > BLK_CNT_W'(1)) || (wtr_q > BLK_CNT_W'(1)))) &&
        !(is_wr && ((ccd_q > BLK_CNT_W'(1)) || (rtw_q > BLK_CNT_W'(1))));
    assign accept   = up.cmd_vld_i && cmd_rdy;
    assign rd_issue = accept && is_rd;
    assign wr_issue = accept && is_wr;
    assign underrun = dfi_wren_o && !up.wr_vld_i;
    assign stray_rd = dfi_rvld_i && (rd_out_q == '0);

    always_comb begin
        cke_d    = ctl_cke_i;
        rst_n_d  = ctl_rst_ni;
        cs_n_d   = 1'b0;
        cmd_d    = CMD_NOP;
        bank_d   = bank_q;
        addr_d   = addr_q;
        ccd_d    = sat_dec(ccd_q);
        wtr_d    = sat_dec(wtr_q);
        rtw_d    = sat_dec(rtw_q);
        rd_out_d = rd_out_q;
        err_d    = err_q | underrun | stray_rd;
        if (accept) begin
            cmd_d  = up.cmd_cmd_i;
            bank_d = up.cmd_ba_i;
            addr_d = up.cmd_adr_i;
        end
        if (rd_issue) begin
            ccd_d = BLK_CNT_W'(BURST_CYCLES);
            rtw_d = BLK_CNT_W'(RTW_CYCLES);
        end
        if (wr_issue) begin
            ccd_d = BLK_CNT_W'(BURST_CYCLES);
            wtr_d = BLK_CNT_W'(WTR_CYCLES);
        end
        // Issue and completion in the same cycle cancel out.
        if (rd_issue && !dfi_last_i) begin
            rd_out_d = rd_out_q + 4'd1;
        end else if (!rd_issue && dfi_last_i && (rd_out_q != '0)) begin
            rd_out_d = rd_out_q - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cke_q    <= 1'b0;
            rst_n_q  <= 1'b0;
            cs_n_q   <= 1'b1;
            cmd_q    <= CMD_NOP;
            bank_q   <= '0;
            addr_q   <= '0;
            ccd_q    <= '0;
            wtr_q    <= '0;
            rtw_q    <= '0;
            rd_out_q <= '0;
            err_q    <= 1'b0;
        end else begin
            cke_q    <= cke_d;
            rst_n_q  <= rst_n_d;
            cs_n_q   <= cs_n_d;
            cmd_q    <= cmd_d;
            bank_q   <= bank_d;
            addr_q   <= addr_d;
            ccd_q    <= ccd_d;
            wtr_q    <= wtr_d;
            rtw_q    <= rtw_d;
            rd_out_q <= rd_out_d;
            err_q    <= err_d;
        end
    end

    // Delay lines are fed in the accept cycle; tap 0 lines up with the
    // command appearing on the DFI bus one cycle later.
    ddr3_dfi_delay #(.TAP(WR_LATENCY - 1), .LEN(1)) u_wstb (
        .clock(clock), .reset(reset), .pulse_i(wr_issue), .pulse_o(dfi_wstb_o)
    );
    ddr3_dfi_delay #(.TAP(WR_LATENCY), .LEN(BURST_CYCLES)) u_wren (
        .clock(clock), .reset(reset), .pulse_i(wr_issue), .pulse_o(dfi_wren_o)
    );
    ddr3_dfi_delay #(.TAP(RD_LATENCY), .LEN(BURST_CYCLES)) u_rden (
        .clock(clock), .reset(reset), .pulse_i(rd_issue), .pulse_o(dfi_rden_o)
    );
`ifdef DDR3_DFI_ODT_EN
    ddr3_dfi_delay #(.TAP(WR_LATENCY - 2), .LEN(ODT_CYCLES)) u_odt (
        .clock(clock), .reset(reset), .pulse_i(wr_issue), .pulse_o(dfi_odt_o)
    );
`else
    assign dfi_odt_o = 1'b0;
`endif

    assign dfi_cke_o  = cke_q;
    assign dfi_rst_no = rst_n_q;
    assign dfi_cs_no  = cs_n_q;
    assign dfi_ras_no = cmd_q[2];
    assign dfi_cas_no = cmd_q[1];
    assign dfi_we_no  = cmd_q[0];
    assign dfi_bank_o = bank_q;
    assign dfi_addr_o = addr_q;
    assign err_o      = err_q;

    // An underrun beat is written with all bytes masked off.
    assign dfi_mask_o = underrun ? '0 : up.wr_mask_i;
    assign dfi_data_o = up.wr_data_i;

    assign up.cmd_rdy_o = cmd_rdy;
    assign up.wr_rdy_o  = dfi_wren_o;
    assign up.rd_vld_o  = dfi_rvld_i;
    assign up.rd_last_o = dfi_last_i;
    assign up.rd_data_o = dfi_data_i;

endmodule

// File: tb/tb_ddr3_dfi_seq.sv
`timescale 1ns/1ps
module tb_ddr3_dfi_seq;
    import ddr3_dfi_pkg::*;

    localparam int DDR3_WIDTH = 16;
    localparam int ADDR_BITS  = 14;
    localparam int WR_LATENCY = 5;
    localparam int RD_LATENCY = 6;
    localparam int WTR_CYCLES = 13;
    localparam int RTW_CYCLES = 7;
    localparam int DW         = 2 * DDR3_WIDTH;
    localparam int MW         = DDR3_WIDTH / 4;
    localparam int HORIZON    = 4096;

    typedef struct { logic [DW-1:0] data; logic [MW-1:0] mask; } wr_beat_t;
    typedef struct { int cyc; logic [DW-1:0] data; logic last; } rd_beat_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ctl_cke_i = 1'b0;
    logic ctl_rst_ni = 1'b0;
    logic err_o, dfi_cke_o, dfi_rst_no, dfi_cs_no, dfi_ras_no, dfi_cas_no, dfi_we_no, dfi_odt_o;
    logic [2:0]           dfi_bank_o;
    logic [ADDR_BITS-1:0] dfi_addr_o;
    logic dfi_wstb_o, dfi_wren_o, dfi_rden_o;
    logic [MW-1:0] dfi_mask_o;
    logic [DW-1:0] dfi_data_o;
    logic dfi_rvld_i = 1'b0;
    logic dfi_last_i = 1'b0;
    logic [DW-1:0] dfi_data_i = '0;

    ddr3_dfi_seq_if #(.DDR3_WIDTH(DDR3_WIDTH), .ADDR_BITS(ADDR_BITS)) up_if ();

    ddr3_dfi_seq #(
        .DDR3_WIDTH(DDR3_WIDTH), .ADDR_BITS(ADDR_BITS), .WR_LATENCY(WR_LATENCY),
        .RD_LATENCY(RD_LATENCY), .WTR_CYCLES(WTR_CYCLES), .RTW_CYCLES(RTW_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .ctl_cke_i(ctl_cke_i), .ctl_rst_ni(ctl_rst_ni),
        .up(up_if), .err_o(err_o),
        .dfi_cke_o(dfi_cke_o), .dfi_rst_no(dfi_rst_no), .dfi_cs_no(dfi_cs_no),
        .dfi_ras_no(dfi_ras_no), .dfi_cas_no(dfi_cas_no), .dfi_we_no(dfi_we_no),
        .dfi_odt_o(dfi_odt_o), .dfi_bank_o(dfi_bank_o), .dfi_addr_o(dfi_addr_o),
        .dfi_wstb_o(dfi_wstb_o), .dfi_wren_o(dfi_wren_o), .dfi_mask_o(dfi_mask_o),
        .dfi_data_o(dfi_data_o), .dfi_rden_o(dfi_rden_o),
        .dfi_rvld_i(dfi_rvld_i), .dfi_last_i(dfi_last_i), .dfi_data_i(dfi_data_i)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state
    bit mon_en = 1'b0;
    bit exp_wstb [HORIZON];
    bit exp_wren [HORIZON];
    bit exp_rden [HORIZON];
    bit exp_odt  [HORIZON];
    logic [2:0]           exp_cmd  = CMD_NOP;
    logic [2:0]           exp_bank = '0;
    logic [ADDR_BITS-1:0] exp_addr = '0;
    bit exp_err = 1'b0;
    int outstanding = 0;
    int drop_cyc = -1;
    int last_acc_cyc = 0;
    wr_beat_t wr_q[$];
    rd_beat_t phy_q[$];
    rd_beat_t rd_exp_q[$];

    // Write-data source and PHY read-return model
    always @(posedge clock) begin
        rd_beat_t r;
        #1;
        up_if.wr_vld_i  = (wr_q.size() != 0) && (cyc != drop_cyc);
        up_if.wr_data_i = (wr_q.size() != 0) ? wr_q[0].data : '0;
        up_if.wr_mask_i = (wr_q.size() != 0) ? wr_q[0].mask : '0;
        if (phy_q.size() != 0 && phy_q[0].cyc == cyc) begin
            r = phy_q.pop_front();
            dfi_rvld_i = 1'b1;
            dfi_last_i = r.last;
            dfi_data_i = r.data;
            rd_exp_q.push_back(r);
        end else begin
            dfi_rvld_i = 1'b0;
            dfi_last_i = 1'b0;
            dfi_data_i = '0;
        end
    end

    // Monitor: compare this cycle, then advance the model
    always @(negedge clock) begin
        wr_beat_t   b;
        rd_beat_t   r;
        logic       acc;
        logic [2:0] c;
        int         t;
        if (mon_en) begin
            check("cs_n", dfi_cs_no, 1'b0);
            check("cmd", {dfi_ras_no, dfi_cas_no, dfi_we_no}, exp_cmd);
            check("bank", dfi_bank_o, exp_bank);
            check("addr", dfi_addr_o, exp_addr);
            check("wstb", dfi_wstb_o, exp_wstb[cyc]);
            check("wren", dfi_wren_o, exp_wren[cyc]);
            check("wr_rdy", up_if.wr_rdy_o, exp_wren[cyc]);
            check("rden", dfi_rden_o, exp_rden[cyc]);
            check("odt", dfi_odt_o, exp_odt[cyc]);
            if (exp_wren[cyc]) begin
                check("wr_beat_avail", wr_q.size() != 0, 1'b1);
                if (wr_q.size() != 0) begin
                    b = wr_q.pop_front();
                    check("wr_data", dfi_data_o, b.data);
                    check("wr_mask", dfi_mask_o, (cyc == drop_cyc) ? MW'(0) : b.mask);
                end
            end
            if (rd_exp_q.size() != 0 && rd_exp_q[0].cyc == cyc) begin
                r = rd_exp_q.pop_front();
                check("rd_vld", up_if.rd_vld_o, 1'b1);
                check("rd_data", up_if.rd_data_o, r.data);
                check("rd_last", up_if.rd_last_o, r.last);
            end else begin
                check("rd_vld", up_if.rd_vld_o, 1'b0);
            end
            check("err", err_o, exp_err);

            if (exp_wren[cyc] && cyc == drop_cyc) exp_err = 1'b1;
            if (dfi_rvld_i && outstanding == 0) exp_err = 1'b1;
            acc = up_if.cmd_vld_i && up_if.cmd_rdy_o;
            c = up_if.cmd_cmd_i;
            exp_cmd = CMD_NOP;
            if (acc) begin
                exp_cmd = c;
                exp_bank = up_if.cmd_ba_i;
                exp_addr = up_if.cmd_adr_i;
                last_acc_cyc = cyc;
                t = cyc + 1;  // command visible on the DFI bus
                if (c == CMD_WR && t + WR_LATENCY + 6 < HORIZON) begin
                    exp_wstb[t + WR_LATENCY - 1] = 1'b1;
                    for (int i = 0; i < BURST_CYCLES; i++) begin
                        exp_wren[t + WR_LATENCY + i] = 1'b1;
                        b.data = DW'($urandom());
                        b.mask = MW'($urandom_range(1, 15));
                        wr_q.push_back(b);
                    end
`ifdef DDR3_DFI_ODT_EN
                    for (int k = t + WR_LATENCY - 2; k <= t + WR_LATENCY + 5; k++) exp_odt[k] = 1'b1;
`endif
                end
                if (c == CMD_RD && t + RD_LATENCY + 6 < HORIZON) begin
                    for (int i = 0; i < BURST_CYCLES; i++) begin
                        exp_rden[t + RD_LATENCY + i] = 1'b1;
                        r.cyc  = t + RD_LATENCY + 1 + i;
                        r.data = DW'($urandom());
                        r.last = (i == BURST_CYCLES - 1);
                        phy_q.push_back(r);
                    end
                end
            end
            if (acc && c == CMD_RD && !dfi_last_i) outstanding++;
            else if (!(acc && c == CMD_RD) && dfi_last_i && outstanding > 0) outstanding--;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Offer a command until accepted (bounded); returns cycles spent refused.
    task automatic issue_cmd(input logic [2:0] c, output int waited);
        waited = 0;
        up_if.cmd_vld_i = 1'b1;
        up_if.cmd_cmd_i = c;
        up_if.cmd_ba_i  = 3'($urandom());
        up_if.cmd_adr_i = ADDR_BITS'($urandom());
        while (waited < 64) begin
            @(negedge clock);
            if (up_if.cmd_rdy_o) break;
            waited++;
        end
        @(posedge clock);
        #1;
        up_if.cmd_vld_i = 1'b0;
        up_if.cmd_cmd_i = CMD_NOP;
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        check("rst_cke", dfi_cke_o, 1'b0);
        check("rst_rst_n", dfi_rst_no, 1'b0);
        check("rst_cs_n", dfi_cs_no, 1'b1);
        check("rst_cmd", {dfi_ras_no, dfi_cas_no, dfi_we_no}, 3'b111);
        check("rst_bank", dfi_bank_o, 3'b000);
        check("rst_addr", dfi_addr_o, '0);
        check("rst_strobes", {dfi_odt_o, dfi_wstb_o, dfi_wren_o, dfi_rden_o}, 4'b0000);
        check("rst_err", err_o, 1'b0);
        check("rst_cmd_rdy", up_if.cmd_rdy_o, 1'b0);
        for (int i = 0; i < HORIZON; i++) begin
            exp_wstb[i] = 1'b0;
            exp_wren[i] = 1'b0;
            exp_rden[i] = 1'b0;
            exp_odt[i]  = 1'b0;
        end
        wr_q.delete();
        phy_q.delete();
        rd_exp_q.delete();
        exp_cmd = CMD_NOP;
        exp_bank = '0;
        exp_addr = '0;
        exp_err = 1'b0;
        outstanding = 0;
        drop_cyc = -1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        mon_en = 1'b1;
    endtask

    initial begin
        int w;
        up_if.cmd_vld_i = 1'b0;
        up_if.cmd_cmd_i = CMD_NOP;
        up_if.cmd_ba_i  = '0;
        up_if.cmd_adr_i = '0;
        idle(2);
        do_reset();

        // CKE / RESET# follow their requests one cycle later
        ctl_cke_i  = 1'b1;
        ctl_rst_ni = 1'b1;
        @(negedge clock);
        check("cke_before", dfi_cke_o, 1'b0);
        idle(1);
        @(negedge clock);
        check("cke_after", dfi_cke_o, 1'b1);
        check("rst_n_after", dfi_rst_no, 1'b1);
        idle(3);

        // Single write
        issue_cmd(CMD_WR, w); check("wr_wait", w, 0);
        idle(15);

        // Back-to-back writes at tCCD
        issue_cmd(CMD_WR, w); check("wr_wait", w, 0);
        issue_cmd(CMD_WR, w); check("ccd_wr_wait", w, BURST_CYCLES - 1);
        idle(15);

        // Write then read: write-to-read turnaround
        issue_cmd(CMD_WR, w); check("wr_wait", w, 0);
        issue_cmd(CMD_RD, w); check("wtr_wait", w, WTR_CYCLES - 1);
        idle(15);

        // Read then write: read-to-write turnaround
        issue_cmd(CMD_RD, w); check("rd_wait", w, 0);
        issue_cmd(CMD_WR, w); check("rtw_wait", w, RTW_CYCLES - 1);
        idle(15);

        // Back-to-back reads, then non-data commands are never blocked
        issue_cmd(CMD_RD, w); check("rd_wait", w, 0);
        issue_cmd(CMD_RD, w); check("ccd_rd_wait", w, BURST_CYCLES - 1);
        issue_cmd(CMD_ACT, w); check("act_wait", w, 0);
        idle(15);
        issue_cmd(CMD_WR, w); check("wr_wait", w, 0);
        issue_cmd(CMD_PRE, w); check("pre_wait", w, 0);
        issue_cmd(CMD_REF, w); check("ref_wait", w, 0);
        idle(15);

        // Write underrun on the second data cycle: masked beat, sticky error
        issue_cmd(CMD_WR, w); check("wr_wait", w, 0);
        drop_cyc = last_acc_cyc + 1 + WR_LATENCY + 1;
        idle(20);
        check("err_sticky", err_o, 1'b1);
        do_reset();
        check("err_cleared", err_o, 1'b0);

        // Read data with nothing outstanding
        begin
            rd_beat_t r;
            r.cyc  = cyc + 2;
            r.data = DW'($urandom());
            r.last = 1'b1;
            phy_q.push_back(r);
        end
        idle(6);
        check("err_stray_rd", err_o, 1'b1);
        do_reset();

        // Reset in the middle of a write burst aborts it
        issue_cmd(CMD_WR, w); check("wr_wait", w, 0);
        idle(WR_LATENCY + 1);
        do_reset();
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
